// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU request at a time becomes a single-beat AXI4 read or write.
// Covers lane steering, load extension, misalignment, ID-matched responses and response timeout.
module ysyx_23060208_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [XLEN-1:0]         req_wdata,

    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [XLEN-1:0]         resp_rdata,
    output logic [1:0]              resp_err,

    output logic                    dsram_arvalid,
    input  logic                    dsram_arready,
    output logic [ADDR_WIDTH-1:0]   dsram_araddr,
    output logic [ID_WIDTH-1:0]     dsram_arid,
    output logic [7:0]              dsram_arlen,
    output logic [2:0]              dsram_arsize,
    output logic [1:0]              dsram_arburst,

    input  logic                    dsram_rvalid,
    output logic                    dsram_rready,
    input  logic [BUS_WIDTH-1:0]    dsram_rdata,
    input  logic [1:0]              dsram_rresp,
    input  logic                    dsram_rlast,
    input  logic [ID_WIDTH-1:0]     dsram_rid,

    output logic                    dsram_awvalid,
    input  logic                    dsram_awready,
    output logic [ADDR_WIDTH-1:0]   dsram_awaddr,
    output logic [ID_WIDTH-1:0]     dsram_awid,
    output logic [7:0]              dsram_awlen,
    output logic [2:0]              dsram_awsize,
    output logic [1:0]              dsram_awburst,

    output logic                    dsram_wvalid,
    input  logic                    dsram_wready,
    output logic [BUS_WIDTH-1:0]    dsram_wdata,
    output logic [BUS_WIDTH/8-1:0]  dsram_wstrb,
    output logic                    dsram_wlast,

    input  logic                    dsram_bvalid,
    output logic                    dsram_bready,
    input  logic [1:0]              dsram_bresp,
    input  logic [ID_WIDTH-1:0]     dsram_bid
);

    localparam int NB   = BUS_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_MIS = 2'd1;
    localparam logic [1:0] ERR_BUS = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [1:0]             r_size;
    logic                   r_uns;
    logic [XLEN-1:0]        r_wdata;
    logic [ID_WIDTH-1:0]    r_id;
    logic [ID_WIDTH-1:0]    r_id_cnt;
    logic [TW-1:0]          r_tcnt;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic [XLEN-1:0]        r_rdata;
    logic [1:0]             r_err;

    logic                   w_misal;
    logic                   w_tmo;
    logic                   w_busy;
    logic                   w_r_hit;
    logic                   w_b_hit;
    logic                   w_aw_fire;
    logic                   w_w_fire;
    logic [OFFW-1:0]        w_off;
    logic [31:0]            w_lane;
    logic [XLEN-1:0]        w_ld;
    logic [BUS_WIDTH-1:0]   w_wrep;
    logic [NB-1:0]          w_mask;
    logic                   w_unused;

    assign w_misal   = ((req_size == 2'd1) && req_addr[0])
                    || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                    || (req_size == 2'd3);
    assign w_tmo     = (TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_busy    = (r_state == S_AR) || (r_state == S_R)
                    || (r_state == S_AWW) || (r_state == S_B);
    assign w_r_hit   = dsram_rvalid && (dsram_rid == r_id);
    assign w_b_hit   = dsram_bvalid && (dsram_bid == r_id);
    assign w_aw_fire = dsram_awvalid && dsram_awready;
    assign w_w_fire  = dsram_wvalid && dsram_wready;
    assign w_off     = r_addr[OFFW-1:0];
    assign w_unused  = ^{dsram_rlast, dsram_rresp[0], dsram_bresp[0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A completing response beats the timeout; an address/data handshake does not,
    // since the counter would already be past its limit in the following state.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (req_valid) w_next = w_misal ? S_RESP : (req_wen ? S_AWW : S_AR);
            S_AR: begin
                if (w_tmo)              w_next = S_RESP;
                else if (dsram_arready) w_next = S_R;
            end
            S_R:    if (w_r_hit || w_tmo) w_next = S_RESP;
            S_AWW: begin
                if (w_tmo) w_next = S_RESP;
                else if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_B;
            end
            S_B:    if (w_b_hit || w_tmo) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_lane = 32'(dsram_rdata >> {w_off, 3'b000});

    always_comb begin
        w_ld = '0;
        unique case (r_size)
            2'd0: w_ld = {{(XLEN-8){~r_uns & w_lane[7]}}, w_lane[7:0]};
            2'd1: w_ld = {{(XLEN-16){~r_uns & w_lane[15]}}, w_lane[15:0]};
            default: begin
                if (r_uns) w_ld = XLEN'(w_lane);
                else       w_ld = XLEN'($signed(w_lane));
            end
        endcase
    end

    always_comb begin
        w_wrep = {NB{r_wdata[7:0]}};
        w_mask = NB'(4'h1);
        unique case (r_size)
            2'd1: begin
                w_wrep = {(NB/2){r_wdata[15:0]}};
                w_mask = NB'(4'h3);
            end
            2'd2: begin
                w_wrep = {(NB/4){r_wdata[31:0]}};
                w_mask = NB'(4'hF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_wdata   <= '0;
            r_id      <= '0;
            r_id_cnt  <= '0;
            r_tcnt    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= '0;
        end else begin
            if (r_state == S_IDLE) r_tcnt <= '0;
            else if (w_busy)       r_tcnt <= r_tcnt + TW'(1);

            unique case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr    <= req_addr;
                    r_size    <= req_size;
                    r_uns     <= req_unsigned;
                    r_wdata   <= req_wdata;
                    r_id      <= r_id_cnt;
                    r_id_cnt  <= r_id_cnt + ID_WIDTH'(1);
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_rdata   <= '0;
                    r_err     <= w_misal ? ERR_MIS : ERR_OK;
                end
                S_AR: if (w_tmo) r_err <= ERR_TMO;
                S_R: begin
                    if (w_r_hit) begin
                        r_err   <= dsram_rresp[1] ? ERR_BUS : ERR_OK;
                        r_rdata <= dsram_rresp[1] ? '0 : w_ld;
                    end else if (w_tmo) begin
                        r_err   <= ERR_TMO;
                    end
                end
                S_AWW: begin
                    if (w_aw_fire) r_aw_done <= 1'b1;
                    if (w_w_fire)  r_w_done  <= 1'b1;
                    if (w_tmo)     r_err     <= ERR_TMO;
                end
                S_B: begin
                    if (w_b_hit)    r_err <= dsram_bresp[1] ? ERR_BUS : ERR_OK;
                    else if (w_tmo) r_err <= ERR_TMO;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = resp_valid ? r_rdata : '0;
    assign resp_err      = resp_valid ? r_err : '0;

    assign dsram_arvalid = (r_state == S_AR);
    assign dsram_araddr  = r_addr;
    assign dsram_arid    = r_id;
    assign dsram_arlen   = 8'd0;
    assign dsram_arsize  = {1'b0, r_size};
    assign dsram_arburst = 2'b01;
    assign dsram_rready  = (r_state == S_R);

    assign dsram_awvalid = (r_state == S_AWW) && !r_aw_done;
    assign dsram_awaddr  = r_addr;
    assign dsram_awid    = r_id;
    assign dsram_awlen   = 8'd0;
    assign dsram_awsize  = {1'b0, r_size};
    assign dsram_awburst = 2'b01;

    assign dsram_wvalid  = (r_state == S_AWW) && !r_w_done;
    assign dsram_wdata   = w_wrep;
    assign dsram_wstrb   = dsram_wvalid ? NB'(w_mask << w_off) : '0;
    assign dsram_wlast   = dsram_wvalid;
    assign dsram_bready  = (r_state == S_B);

endmodule
